// File: rtl/pixel_seq_ctrl.sv
// pixel_seq_ctrl: pixel reset/integrate/readout sequencer with event counting.
// Optional PIXSEQ_WDT_EN adds a watchdog on the PRST and MSET waits that sets a sticky ERR.
module pixel_seq_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        trg_mode_i,
  input  logic        trg_det_i,
  input  logic [15:0] integ_len_i,
  input  logic [7:0]  read_len_i,
  input  logic [7:0]  evt_num_i,
  input  logic        pix_reset_busy_i,
  input  logic        pix_end_i,
  input  logic        mem_set_done_i,
  input  logic        last_mem_i,
  output logic        pix_reset_o,
  output logic        pix_store_o,
  output logic        store_reset_o,
  output logic        mem_set_en_o,
  output logic        mem_set_clr_o,
  output logic        read_valid_o,
  output logic        evt_num_end_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [7:0]  evt_cnt_o,
  output logic [2:0]  state_o
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, PRST = 3'd1, INTEG = 3'd2, HOLD = 3'd3,
    MCLR = 3'd4, MSET = 3'd5, READ = 3'd6, EVT = 3'd7
  } state_e;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, integ_q, integ_d;
  logic [7:0]  read_q, read_d, evt_num_q, evt_num_d, evt_cnt_q, evt_cnt_d;
  logic        trg_q, trg_d, evt_end_q, evt_end_d, busy_q, busy_d;
  logic        pix_reset_q, pix_reset_d, pix_store_q, pix_store_d, store_reset_q, store_reset_d;
  logic        mem_set_en_q, mem_set_en_d, mem_set_clr_q, mem_set_clr_d, read_valid_q, read_valid_d;
  logic        integ_last, read_last;
`ifdef PIXSEQ_WDT_EN
  logic        err_q, err_d, wdt_hit;
  assign wdt_hit = cnt_q[7:0] == 8'd254;
  assign err_o   = err_q;
`else
  assign err_o   = 1'b0;
`endif
  // Zero lengths fall out as one cycle because the compare is against count+1.
  assign integ_last = cnt_q + 16'd1 >= integ_q;
  assign read_last  = cnt_q + 16'd1 >= {8'd0, read_q};
  always_comb begin
    state_d   = state_q;
    trg_d     = trg_q;
    integ_d   = integ_q;
    read_d    = read_q;
    evt_num_d = evt_num_q;
    evt_cnt_d = evt_cnt_q;
    evt_end_d = evt_end_q;
`ifdef PIXSEQ_WDT_EN
    err_d     = err_q;
`endif
    if (abort_i) state_d = IDLE;
    else case (state_q)
      IDLE: if (start_i) begin
        state_d   = PRST;
        trg_d     = trg_mode_i;
        integ_d   = integ_len_i;
        read_d    = read_len_i;
        evt_num_d = evt_num_i;
        evt_cnt_d = '0;
        evt_end_d = 1'b0;
`ifdef PIXSEQ_WDT_EN
        err_d     = 1'b0;
`endif
      end
      PRST: if (pix_end_i) state_d = INTEG;
`ifdef PIXSEQ_WDT_EN
        else if (wdt_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
`endif
      INTEG: if (trg_q ? trg_det_i : integ_last) state_d = HOLD;
      HOLD: state_d = MCLR;
      MCLR: state_d = MSET;
      // Holding MSET for at least two cycles keeps MEM_SET_EN pulses two low cycles apart.
      MSET: if (mem_set_done_i && !mem_set_en_q) state_d = READ;
`ifdef PIXSEQ_WDT_EN
        else if (wdt_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
`endif
      READ: if (read_last) begin
        state_d   = last_mem_i ? EVT : MSET;
        evt_cnt_d = !last_mem_i ? evt_cnt_q : (evt_cnt_q == 8'hFF) ? evt_cnt_q : evt_cnt_q + 8'd1;
      end
      EVT: if (evt_num_q != 8'd0 && evt_cnt_q == evt_num_q) begin
        state_d   = IDLE;
        evt_end_d = 1'b1;
      end else state_d = PRST;
      default: state_d = IDLE;
    endcase
    cnt_d         = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
    pix_store_d   = state_d == PRST || state_d == INTEG;
    pix_reset_d   = state_d == PRST && !trg_d && (state_q != PRST || (pix_reset_q && !pix_reset_busy_i));
    store_reset_d = state_d == EVT;
    mem_set_en_d  = state_d == MSET && state_q != MSET;
    mem_set_clr_d = state_d == MCLR;
    read_valid_d  = state_d == READ;
    busy_d        = state_d != IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      trg_q         <= 1'b0;
      integ_q       <= '0;
      read_q        <= '0;
      evt_num_q     <= '0;
      evt_cnt_q     <= '0;
      evt_end_q     <= 1'b0;
      busy_q        <= 1'b0;
      pix_reset_q   <= 1'b0;
      pix_store_q   <= 1'b0;
      store_reset_q <= 1'b0;
      mem_set_en_q  <= 1'b0;
      mem_set_clr_q <= 1'b0;
      read_valid_q  <= 1'b0;
`ifdef PIXSEQ_WDT_EN
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      trg_q         <= trg_d;
      integ_q       <= integ_d;
      read_q        <= read_d;
      evt_num_q     <= evt_num_d;
      evt_cnt_q     <= evt_cnt_d;
      evt_end_q     <= evt_end_d;
      busy_q        <= busy_d;
      pix_reset_q   <= pix_reset_d;
      pix_store_q   <= pix_store_d;
      store_reset_q <= store_reset_d;
      mem_set_en_q  <= mem_set_en_d;
      mem_set_clr_q <= mem_set_clr_d;
      read_valid_q  <= read_valid_d;
`ifdef PIXSEQ_WDT_EN
      err_q         <= err_d;
`endif
    end
  end
  assign pix_reset_o   = pix_reset_q;
  assign pix_store_o   = pix_store_q;
  assign store_reset_o = store_reset_q;
  assign mem_set_en_o  = mem_set_en_q;
  assign mem_set_clr_o = mem_set_clr_q;
  assign read_valid_o  = read_valid_q;
  assign evt_num_end_o = evt_end_q;
  assign busy_o        = busy_q;
  assign evt_cnt_o     = evt_cnt_q;
  assign state_o       = state_q;
endmodule

// File: doc/pixel_seq_ctrl.md
PIXEL_SEQ_CTRL -- requirements
Module: pixel_seq_ctrl

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, 25 MHz, all logic on rising edge.
REQ-002 SHALL have: RST  in  1  synchronous, active-high reset.
REQ-003 SHALL have: START  in  1  run-start request, sampled in IDLE only; ABORT  in  1  return to IDLE.
REQ-004 SHALL have: TRG_MODE  in  1  external-trigger mode; TRG_DET  in  1  trigger detected.
REQ-005 SHALL have: INTEG_LEN  in  16  integration cycles; READ_LEN  in  8  readout-window cycles per memory; EVT_NUM  in  8  events per run, 0 = unlimited.
REQ-006 SHALL have: PIX_RESET_BUSY, PIX_END, MEM_SET_DONE, LAST_MEM  in  1 each  status from pixel control.
REQ-007 SHALL have: PIX_RESET, PIX_STORE, STORE_RESET, MEM_SET_EN, MEM_SET_CLR  out  1 each  commands to pixel control.
REQ-008 SHALL have: READ_VALID  out  1  readout window; EVT_NUM_END  out  1  event quota reached; BUSY  out  1  not IDLE; ERR  out  1  sticky watchdog error.
REQ-009 SHALL have: EVT_CNT  out  8  completed events; STATE  out  3  current state code.

Function
REQ-010 FSM states and codes SHALL be IDLE=0, PRST=1, INTEG=2, HOLD=3, MCLR=4, MSET=5, READ=6, EVT=7; all outputs registered.
REQ-011 IDLE: on START=1 SHALL clear EVT_CNT and EVT_NUM_END, go PRST next cycle; BUSY=0 only in IDLE.
REQ-012 PRST: PIX_STORE=1; PIX_RESET=1 until first cycle PIX_RESET_BUSY=1 seen, then 0; on PIX_END=1 SHALL go INTEG.
REQ-013 PRST with TRG_MODE=1: PIX_RESET SHALL stay 0 (reset launched by PIX_STORE rising edge); PIX_END still exits.
REQ-014 INTEG: PIX_STORE=1; TRG_MODE=0 -> exit after exactly INTEG_LEN cycles (INTEG_LEN=0 treated as 1); TRG_MODE=1 -> exit on first TRG_DET=1, counter ignored.
REQ-015 HOLD: PIX_STORE SHALL drop to 0 for exactly 1 cycle before MCLR.
REQ-016 MCLR: MEM_SET_CLR=1 for exactly 1 cycle, then MSET.
REQ-017 MSET: MEM_SET_EN=1 for the first cycle only, then 0; on MEM_SET_DONE=1 SHALL go READ.
REQ-018 READ: READ_VALID=1 for exactly READ_LEN cycles (0 treated as 1); LAST_MEM sampled on last READ cycle: 1 -> EVT, 0 -> MSET.
REQ-019 Between two MEM_SET_EN pulses MEM_SET_EN SHALL be low at least 2 cycles.
REQ-020 EVT: STORE_RESET=1 for 1 cycle; EVT_CNT +1, saturating at 255.
REQ-021 EVT: if EVT_NUM!=0 and incremented EVT_CNT==EVT_NUM -> EVT_NUM_END=1 (held until next START) and IDLE; else PRST.
REQ-022 ABORT=1 in any state SHALL force IDLE next cycle with all command outputs 0; EVT_CNT, EVT_NUM_END, ERR retained.
REQ-023 START=1 while not IDLE SHALL be ignored; ABORT beats START when simultaneous.
REQ-024 Configuration inputs SHALL be sampled at START and held for the run.

Reset
REQ-025 RST=1 SHALL set STATE=IDLE and every output to 0, including EVT_CNT, EVT_NUM_END, ERR.
REQ-026 RST SHALL take priority over ABORT and START and act mid-run on the next edge.

Configuration
REQ-027 Macro PIXSEQ_WDT_EN defined: 8-bit watchdog counts cycles in PRST and MSET waits; reaching 255 sets ERR=1 (sticky until RST or START) and forces IDLE.
REQ-028 PIXSEQ_WDT_EN undefined: waits are unbounded, ERR tied to 0, no watchdog logic.

Verification
REQ-029 TRG_MODE=0, INTEG_LEN=100, READ_LEN=4, EVT_NUM=2, LAST_MEM=1 after 2nd MSET -> 2 events, 4 MEM_SET_EN pulses, 16 READ_VALID cycles, EVT_NUM_END=1, EVT_CNT=2, IDLE.
REQ-030 TRG_MODE=1, TRG_DET at cycle 500 of INTEG -> PIX_RESET never 1, HOLD entered one cycle after TRG_DET.
REQ-031 ABORT during READ -> IDLE next cycle, READ_VALID=0, EVT_CNT unchanged.
REQ-032 RST asserted in MSET -> next cycle all outputs 0, STATE=0.
REQ-033 With PIXSEQ_WDT_EN, PIX_END never asserted -> ERR=1 after 255 cycles in PRST, IDLE; without macro, stays PRST.
REQ-034 EVT_NUM=0, 300 events -> EVT_CNT saturates 255, EVT_NUM_END stays 0.
